// File: rtl/rand_server_if.sv
// Handshake bundle between the random-number server and its requesters.
// The limit field exists only when RAND_SRV_RANGE_EN is defined.
interface rand_server_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic            seed_load;
  logic [7:0]      seed;
  logic            rnd_valid;
  logic [NREQ-1:0] grant;
  logic [7:0]      rnd_data;
  logic            busy;
`ifdef RAND_SRV_RANGE_EN
  logic [7:0]      limit;

  modport master (
    output req, seed_load, seed, limit,
    input  rnd_valid, grant, rnd_data, busy
  );
  modport slave (
    input  req, seed_load, seed, limit,
    output rnd_valid, grant, rnd_data, busy
  );
`else
  modport master (
    output req, seed_load, seed,
    input  rnd_valid, grant, rnd_data, busy
  );
  modport slave (
    input  req, seed_load, seed,
    output rnd_valid, grant, rnd_data, busy
  );
`endif
endinterface

// File: rtl/rand_server.sv
// Shared 8-bit LFSR random server with round-robin request/grant and a minimum
// shift gap between draws. Define RAND_SRV_RANGE_EN to add range-limited draws.
module rand_server #(
  parameter int NREQ   = 4,
  parameter int SHIFTS = 8
) (
  input  logic         clock,
  input  logic         reset,
  rand_server_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] GAP_MAX = 4'(SHIFTS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;

  logic [1:0]      r_state;
  logic [7:0]      r_s;
  logic [3:0]      r_gap;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_win;
  logic            r_rnd_valid;
  logic [NREQ-1:0] r_grant;
  logic [7:0]      r_rnd_data;

  logic [7:0]      w_s_step;
  logic [PW-1:0]   w_pick;
  logic            w_found;
  logic [7:0]      w_draw;
  logic            w_accept;

  assign w_s_step = {r_s[6:0], r_s[7] ^ r_s[5] ^ r_s[4] ^ r_s[3]};

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && bus.req[PW'((32'(r_ptr) + i) % NREQ)]) begin
        w_found = 1'b1;
        w_pick  = PW'((32'(r_ptr) + i) % NREQ);
      end
    end
  end

`ifdef RAND_SRV_RANGE_EN
  logic [7:0] w_lim_m1;
  logic [7:0] w_sm1;
  logic [7:0] w_sm2;
  logic [7:0] w_mask;
  logic [7:0] w_masked;

  // Smear limit-1 rightwards to get the smallest all-ones mask covering it.
  always_comb begin
    w_lim_m1 = bus.limit - 8'd1;
    w_sm1    = w_lim_m1 | (w_lim_m1 >> 1);
    w_sm2    = w_sm1 | (w_sm1 >> 2);
    w_mask   = w_sm2 | (w_sm2 >> 4);
    w_masked = r_s & w_mask;
    if (bus.limit == 8'd0) begin
      w_draw   = r_s;
      w_accept = 1'b1;
    end else begin
      w_draw   = w_masked;
      w_accept = (w_masked < bus.limit);
    end
  end
`else
  always_comb begin
    w_draw   = r_s;
    w_accept = 1'b1;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s <= 8'hFF;
    end else if (bus.seed_load) begin
      r_s <= (bus.seed == 8'd0) ? 8'hFF : bus.seed;
    end else begin
      r_s <= w_s_step;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_gap <= '0;
    end else if (r_state == ST_DELIVER) begin
      r_gap <= '0;
    end else if (r_gap < GAP_MAX) begin
      r_gap <= r_gap + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_rnd_valid <= 1'b0;
      r_grant     <= '0;
      r_rnd_data  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_win   <= w_pick;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.req[r_win]) begin
            r_state <= ST_IDLE;
          end else if ((r_gap == GAP_MAX) && w_accept) begin
            r_rnd_data  <= w_draw;
            r_grant     <= NREQ'(1) << r_win;
            r_rnd_valid <= 1'b1;
            r_state     <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          r_rnd_valid <= 1'b0;
          r_grant     <= '0;
          r_ptr       <= (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rnd_valid = r_rnd_valid;
  assign bus.grant     = r_grant;
  assign bus.rnd_data  = r_rnd_data;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rand_server.sv
// Self-checking bench for rand_server: delivery schedule predicted from edge
// arithmetic (gap window, round-robin order) and an integer LFSR model.
module tb_rand_server;

  localparam int NREQ   = 4;
  localparam int SHIFTS = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rand_server_if #(.NREQ(NREQ)) bus ();

  rand_server #(.NREQ(NREQ), .SHIFTS(SHIFTS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: edge-indexed schedule rather than a state machine.
  int              m_s, m_ptr, m_win, m_due, m_clear, m_idle_from, m_edge;
  bit              m_pending, exp_valid, exp_busy;
  logic [NREQ-1:0] exp_grant;
  logic [7:0]      exp_data;

  function automatic int lfsr_next(int s);
    return ((s << 1) & 254) | (((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1);
  endfunction

  function automatic int pick(int p, logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_s = 255; m_ptr = 0; m_win = 0; m_due = 0; m_clear = 0;
    m_idle_from = 1; m_edge = 0; m_pending = 0;
    exp_valid = 0; exp_busy = 0; exp_grant = '0; exp_data = 8'h00;
  endtask

  // Advance one clock: model the edge, return at the following negedge.
  task automatic step();
    logic [NREQ-1:0] r;
    logic            sl;
    logic [7:0]      sd;
    @(posedge clock);
    r = bus.req; sl = bus.seed_load; sd = bus.seed;
    m_edge++;
    exp_valid = 0; exp_grant = '0;
    if (m_pending) begin
      if (!r[m_win]) begin
        m_pending = 0; m_idle_from = m_edge + 1;
      end else if (m_edge == m_due) begin
        exp_valid = 1; exp_grant[m_win] = 1'b1; exp_data = 8'(m_s);
        m_ptr = (m_win + 1) % NREQ; m_clear = m_edge + 1;
        m_idle_from = m_edge + 2; m_pending = 0;
      end
    end else if (m_edge >= m_idle_from && r != '0) begin
      m_win = pick(m_ptr, r); m_pending = 1;
      m_due = max2(m_edge + 1, m_clear + SHIFTS + 1);
    end
    m_s = sl ? ((sd == 8'd0) ? 255 : int'(sd)) : lfsr_next(m_s);
    exp_busy = m_pending || exp_valid;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; bus.req = '0; bus.seed_load = 1'b0; bus.seed = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    int pulse_edge;
    logic [7:0] pdata;
    logic [NREQ-1:0] pgrant;
    pulse_edge = -1; pdata = 8'h00; pgrant = '0;
    #12;
    total++; if (bus.rnd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", bus.rnd_valid); end
    total++; if (bus.grant !== '0) begin bad++; $display("FAIL rst_grant got=%b exp=0", bus.grant); end
    total++; if (bus.rnd_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", bus.rnd_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
    @(negedge clock);
    bus.req = 4'b0001; reset = 1'b0;
    model_reset();
    for (int c = 0; c < 14; c++) begin
      step();
      total++; if (bus.rnd_valid !== exp_valid) begin bad++; $display("FAIL first_valid edge=%0d got=%0b exp=%0b", m_edge, bus.rnd_valid, exp_valid); end
      if (bus.rnd_valid === 1'b1 && pulse_edge < 0) begin
        pulse_edge = m_edge; pdata = bus.rnd_data; pgrant = bus.grant;
      end
      if (bus.rnd_valid === 1'b1) bus.req = bus.req & ~bus.grant;
    end
    total++; if (pulse_edge !== SHIFTS + 1) begin bad++; $display("FAIL first_edge got=%0d exp=%0d", pulse_edge, SHIFTS + 1); end
    total++; if (pdata !== 8'h0B) begin bad++; $display("FAIL first_data got=%h exp=0b", pdata); end
    total++; if (pgrant !== 4'b0001) begin bad++; $display("FAIL first_grant got=%b exp=0001", pgrant); end
  endtask

  task automatic test_round_robin();
    int q_edge[$];
    logic [NREQ-1:0] q_grant[$];
    logic [NREQ-1:0] g;
    do_reset();
    bus.req = '1;
    for (int c = 0; c < 55; c++) begin
      step();
      total++; if (bus.rnd_valid !== exp_valid) begin bad++; $display("FAIL rr_valid edge=%0d got=%0b exp=%0b", m_edge, bus.rnd_valid, exp_valid); end
      if (exp_valid) begin
        total++; if (bus.rnd_data !== exp_data) begin bad++; $display("FAIL rr_data got=%h exp=%h", bus.rnd_data, exp_data); end
      end
      if (bus.rnd_valid === 1'b1) begin q_edge.push_back(m_edge); q_grant.push_back(bus.grant); end
    end
    for (int k = 0; k < 5; k++) begin
      g = '0; g[k % NREQ] = 1'b1;
      total++;
      if (k >= q_grant.size()) begin bad++; $display("FAIL rr_missing idx=%0d got=none exp=%b", k, g); end
      else if (q_grant[k] !== g) begin bad++; $display("FAIL rr_grant idx=%0d got=%b exp=%b", k, q_grant[k], g); end
    end
    for (int k = 1; k < 5; k++) begin
      if (k < q_edge.size()) begin
        total++; if (q_edge[k] - q_edge[k-1] !== SHIFTS + 2) begin bad++; $display("FAIL rr_period idx=%0d got=%0d exp=%0d", k, q_edge[k] - q_edge[k-1], SHIFTS + 2); end
      end
    end
  endtask

  task automatic test_abort();
    logic [NREQ-1:0] first_g;
    first_g = '0;
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if (bus.rnd_valid !== 1'b0) begin bad++; $display("FAIL abort_wait_valid got=%0b exp=0", bus.rnd_valid); end
    end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_busy_wait got=%0b exp=1", bus.busy); end
    bus.req = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (bus.rnd_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%0b exp=0", bus.rnd_valid); end
      total++; if (bus.busy !== exp_busy) begin bad++; $display("FAIL abort_busy got=%0b exp=%0b", bus.busy, exp_busy); end
    end
    bus.req = 4'b0101;
    for (int c = 0; c < 12; c++) begin
      step();
      total++; if (bus.rnd_valid !== exp_valid) begin bad++; $display("FAIL abort_next_valid got=%0b exp=%0b", bus.rnd_valid, exp_valid); end
      if (bus.rnd_valid === 1'b1 && first_g == '0) first_g = bus.grant;
      if (bus.rnd_valid === 1'b1) bus.req = '0;
    end
    total++; if (first_g !== 4'b0001) begin bad++; $display("FAIL abort_next_grant got=%b exp=0001", first_g); end
  endtask

  task automatic test_seed();
    do_reset();
    step(); step();
    bus.seed_load = 1'b1; bus.seed = 8'h00;
    step();
    bus.seed_load = 1'b0;
    total++; if (dut.r_s !== 8'hFF) begin bad++; $display("FAIL seed0_s0 got=%h exp=ff", dut.r_s); end
    step();
    total++; if (dut.r_s !== 8'hFE) begin bad++; $display("FAIL seed0_s1 got=%h exp=fe", dut.r_s); end
    step();
    total++; if (dut.r_s !== 8'hFC) begin bad++; $display("FAIL seed0_s2 got=%h exp=fc", dut.r_s); end
    bus.req = 4'b0010;
    step(); step();
    bus.seed_load = 1'b1; bus.seed = 8'h5A;
    step();
    bus.seed_load = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      total++; if (bus.rnd_valid !== exp_valid) begin bad++; $display("FAIL seedwait_valid edge=%0d got=%0b exp=%0b", m_edge, bus.rnd_valid, exp_valid); end
      if (exp_valid) begin
        total++; if (bus.rnd_data !== exp_data) begin bad++; $display("FAIL seedwait_data got=%h exp=%h", bus.rnd_data, exp_data); end
        total++; if (bus.grant !== exp_grant) begin bad++; $display("FAIL seedwait_grant got=%b exp=%b", bus.grant, exp_grant); end
      end
      if (bus.rnd_valid === 1'b1) bus.req = '0;
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    bus.req = 4'b0001;
    repeat (4) step();
    reset = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midwait_busy got=%0b exp=0", bus.busy); end
    total++; if (bus.rnd_valid !== 1'b0) begin bad++; $display("FAIL midwait_valid got=%0b exp=0", bus.rnd_valid); end
    @(negedge clock); @(negedge clock);
    bus.req = '0; reset = 1'b0; model_reset();
    for (int c = 0; c < 14; c++) begin
      step();
      total++; if (bus.rnd_valid !== 1'b0) begin bad++; $display("FAIL midwait_stale got=%0b exp=0", bus.rnd_valid); end
    end
    bus.req = 4'b0001;
    guard = 0;
    while (!exp_valid && guard < 40) begin step(); guard++; end
    total++; if (bus.rnd_valid !== 1'b1) begin bad++; $display("FAIL middeliver_pulse got=%0b exp=1", bus.rnd_valid); end
    reset = 1'b1;
    #1;
    total++; if (bus.rnd_valid !== 1'b0) begin bad++; $display("FAIL middeliver_valid got=%0b exp=0", bus.rnd_valid); end
    total++; if (bus.grant !== '0) begin bad++; $display("FAIL middeliver_grant got=%b exp=0", bus.grant); end
    total++; if (bus.rnd_data !== 8'h00) begin bad++; $display("FAIL middeliver_data got=%h exp=00", bus.rnd_data); end
    @(negedge clock); @(negedge clock);
    bus.req = '0; reset = 1'b0; model_reset();
    for (int c = 0; c < 14; c++) begin
      step();
      total++; if (bus.rnd_valid !== 1'b0 || bus.grant !== '0) begin bad++; $display("FAIL middeliver_stale got=%0b/%b exp=0/0", bus.rnd_valid, bus.grant); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req[i] && $urandom_range(3) == 0) bus.req[i] = 1'b1;
      bus.seed_load = ($urandom_range(39) == 0);
      bus.seed = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      step();
      total++; if (bus.rnd_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid edge=%0d got=%0b exp=%0b", m_edge, bus.rnd_valid, exp_valid); end
      total++; if (bus.busy !== exp_busy) begin bad++; $display("FAIL rnd_busy edge=%0d got=%0b exp=%0b", m_edge, bus.busy, exp_busy); end
      if (exp_valid) begin
        total++; if (bus.grant !== exp_grant) begin bad++; $display("FAIL rnd_grant edge=%0d got=%b exp=%b", m_edge, bus.grant, exp_grant); end
        total++; if (bus.rnd_data !== exp_data) begin bad++; $display("FAIL rnd_data edge=%0d got=%h exp=%h", m_edge, bus.rnd_data, exp_data); end
      end
      if (bus.rnd_valid === 1'b1) bus.req = bus.req & ~bus.grant;
    end
    bus.seed_load = 1'b0;
  endtask

`ifdef RAND_SRV_RANGE_EN
  task automatic test_range();
    int lims[3];
    int n, guard;
    lims[0] = 1; lims[1] = 10; lims[2] = 0;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      bus.limit = 8'(lims[t]);
      bus.req = 4'b0001;
      n = 0; guard = 0;
      while (n < 1000 && guard < 40000) begin
        @(negedge clock);
        guard++;
        if (bus.rnd_valid === 1'b1) begin
          n++;
          total++;
          if (lims[t] == 0 && bus.rnd_data == 8'h00) begin bad++; $display("FAIL range_raw got=%h exp=nonzero", bus.rnd_data); end
          else if (lims[t] != 0 && int'(bus.rnd_data) >= lims[t]) begin bad++; $display("FAIL range_lim%0d got=%0d exp=<%0d", lims[t], bus.rnd_data, lims[t]); end
        end
      end
      total++; if (n !== 1000) begin bad++; $display("FAIL range_count lim=%0d got=%0d exp=1000", lims[t], n); end
    end
    bus.limit = 8'h00;
  endtask
`endif

  initial begin
    bus.req = '0; bus.seed_load = 1'b0; bus.seed = 8'h00;
`ifdef RAND_SRV_RANGE_EN
    bus.limit = 8'h00;
`endif
    model_reset();
    test_reset();
    test_round_robin();
    test_abort();
    test_seed();
    test_reset_mid();
    test_random();
`ifdef RAND_SRV_RANGE_EN
    test_range();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
